// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a valid/ready handshake backed by a 2-entry skid buffer.
// Emits a NOP bubble when empty or flushed and keeps saturating stall/flush counters.
module pipe_skid_reg #(
  parameter int                   WORD_SIZE  = 32,
  parameter int                   NUM_FIELDS = 2,
  parameter logic [WORD_SIZE-1:0] BUBBLE_VAL = 32'h0000_0013,
  parameter int                   CNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_SIZE*NUM_FIELDS-1:0]  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_SIZE*NUM_FIELDS-1:0]  out_data,
  output logic [1:0]                       occupancy,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic [CNT_W-1:0]                 flush_cnt
);

  localparam int                DATA_W  = WORD_SIZE * NUM_FIELDS;
  // Field 0 carries the NOP encoding; every other field reads zero.
  localparam logic [DATA_W-1:0] BUBBLE  = DATA_W'(BUBBLE_VAL);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic in_fire;
  logic out_fire;

  // Handshake is decoded from registered state only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? main_q : BUBBLE;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A same-cycle in_fire is dropped; the upstream treats it as accepted.
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_fire, out_fire})
            2'b11: main_d = in_data;
            2'b01: state_d = ST_EMPTY;
            2'b10: begin
              skid_d  = in_data;
              state_d = ST_FULL;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stall is judged on the pre-flush view of the outputs.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two payload registers are reset too, so the bubble is defined from the first cycle.
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
